mult_pipe_nxn: RTL and testbench

- Parametrised, fully pipelined integer multiplier; next generation of the team's fixed 8x8 sign-magnitude pipelined multiplier.
- Generalised operand widths and latency. Per-transaction signed/unsigned selection on each operand.
- Valid/ready flow control replaces the free-running pipeline.
- Sits in DCT/IDCT datapaths between the coefficient ROM and the partial-sum accumulators.

---
 rtl/mult_pipe_nxn.sv | 253 +++++++++++++++++++++++++
 tb/tb_mult_pipe_nxn.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_nxn.sv
// Parametrised valid/ready pipelined multiplier with per-operand signed/unsigned selection.
// Optional round/saturate output stage and sat_flag port enabled by defining MULT_ROUND_EN.
module mult_pipe_nxn #(
  parameter int A_W       = 8,
  parameter int B_W       = 8,
  parameter int LAT       = 8,
  parameter int FRAC_BITS = 7,
  parameter int OUT_W     = 8,
`ifdef MULT_ROUND_EN
  localparam int RES_W    = OUT_W
`else
  localparam int RES_W    = A_W + B_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
`ifdef MULT_ROUND_EN
  output logic             sat_flag,
`endif
  output logic             out_signed
);

  localparam int P_W = A_W + B_W;
  localparam int HB  = B_W / 2;
  localparam int ND  = LAT - 3;

  if (LAT < 3 || LAT > 16 || A_W < 1 || B_W < 2 || FRAC_BITS < 0 ||
      OUT_W < 1 || OUT_W > P_W) begin : g_bad_cfg
    $error("mult_pipe_nxn: illegal parameter set");
  end

  typedef struct packed {
    logic           vld;
    logic           neg;
    logic           zero;
    logic           mode;
    logic [P_W-1:0] prod;
  } prod_t;

  function automatic logic [P_W-1:0] row_sum(input logic [A_W-1:0] m,
                                             input logic [B_W-1:0] bits);
    logic [P_W-1:0] acc;
    acc = '0;
    for (int j = 0; j < B_W; j++)
      if (bits[j]) acc = acc + (P_W'(m) << j);
    return acc;
  endfunction

  // One global advance: every stage moves together or everything holds.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Stage 0: raw operand capture
  logic           s0_vld_q, s0_as_q, s0_bs_q;
  logic [A_W-1:0] s0_a_q;
  logic [B_W-1:0] s0_b_q;

  always_ff @(posedge clk) begin
    if (rst)      s0_vld_q <= 1'b0;
    else if (adv) s0_vld_q <= in_valid;
  end

  // NOTE: datapath registers carry no reset; only valid bits and the visible output need a known value.
  always_ff @(posedge clk) begin
    if (adv) begin
      s0_a_q  <= a;
      s0_b_q  <= b;
      s0_as_q <= a_signed;
      s0_bs_q <= b_signed;
    end
  end

  // Stage 1: sign + magnitude, zero detect
  logic           s1_sa_d, s1_sb_d, s1_zero_d;
  logic [A_W-1:0] s1_ma_d;
  logic [B_W-1:0] s1_mb_d;
  logic           s1_vld_q, s1_neg_q, s1_zero_q, s1_mode_q;
  logic [A_W-1:0] s1_ma_q;
  logic [B_W-1:0] s1_mb_q;

  // NOTE: combinational blocks use blocking '=', clocked blocks use non-blocking '<='.
  always_comb begin
    s1_sa_d   = s0_as_q & s0_a_q[A_W-1];
    s1_sb_d   = s0_bs_q & s0_b_q[B_W-1];
    s1_ma_d   = s1_sa_d ? -s0_a_q : s0_a_q;
    s1_mb_d   = s1_sb_d ? -s0_b_q : s0_b_q;
    s1_zero_d = (s0_a_q == '0) | (s0_b_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
    end else if (adv) begin
      s1_vld_q  <= s0_vld_q;
      s1_neg_q  <= s1_sa_d ^ s1_sb_d;
      s1_zero_q <= s1_zero_d;
      s1_mode_q <= s0_as_q | s0_bs_q;
      s1_ma_q   <= s1_ma_d;
      s1_mb_q   <= s1_mb_d;
    end
  end

  // Stage 2: two partial-product sums over the low and high halves of b
  logic [B_W-1:0] lo_b, hi_b;
  logic [P_W-1:0] s2_lo_d, s2_hi_d, s2_lo_q, s2_hi_q;
  logic           s2_vld_q, s2_neg_q, s2_zero_q, s2_mode_q;

  always_comb begin
    lo_b           = s1_mb_q;
    lo_b[B_W-1:HB] = '0;
    hi_b           = s1_mb_q;
    hi_b[HB-1:0]   = '0;
    s2_lo_d        = row_sum(s1_ma_q, lo_b);
    s2_hi_d        = row_sum(s1_ma_q, hi_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
    end else if (adv) begin
      s2_vld_q  <= s1_vld_q;
      s2_neg_q  <= s1_neg_q;
      s2_zero_q <= s1_zero_q;
      s2_mode_q <= s1_mode_q;
      s2_lo_q   <= s2_lo_d;
      s2_hi_q   <= s2_hi_d;
    end
  end

  prod_t s2_sum, tail;

  always_comb begin
    s2_sum      = '0;
    s2_sum.vld  = s2_vld_q;
    s2_sum.neg  = s2_neg_q;
    s2_sum.zero = s2_zero_q;
    s2_sum.mode = s2_mode_q;
    s2_sum.prod = s2_lo_q + s2_hi_q;
  end

  // Remaining middle stages carry the magnitude product up to the negate stage.
  if (ND == 0) begin : g_no_mid
    assign tail = s2_sum;
  end else begin : g_mid
    prod_t mid_q [ND];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < ND; i++) mid_q[i].vld <= 1'b0;
      end else if (adv) begin
        mid_q[0] <= s2_sum;
        for (int i = 1; i < ND; i++) mid_q[i] <= mid_q[i-1];
      end
    end

    assign tail = mid_q[ND-1];
  end

  // Stage LAT: apply sign; the zero flag forces a clean all-zero result.
  logic [P_W-1:0] fin_res_d, fin_res_q;
  logic           fin_vld_q, fin_sgn_q;

  always_comb begin
    fin_res_d = tail.neg ? -tail.prod : tail.prod;
    if (tail.zero) fin_res_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fin_vld_q <= 1'b0;
      fin_res_q <= '0;
      fin_sgn_q <= 1'b0;
    end else if (adv) begin
      fin_vld_q <= tail.vld;
      fin_res_q <= fin_res_d;
      fin_sgn_q <= tail.mode;
    end
  end

`ifdef MULT_ROUND_EN
  localparam int EXT_W = P_W + 2;
  localparam logic signed [EXT_W-1:0] S_MAX = EXT_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [EXT_W-1:0] S_MIN = EXT_W'(-(2 ** (OUT_W - 1)));
  localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'(2 ** OUT_W - 1);

  logic signed [EXT_W-1:0] ext, mag, rnd, val, sat_v;
  logic        [EXT_W-1:0] half;
  logic                    neg, sat_d;
  logic        [OUT_W-1:0] res_d, res_q;
  logic                    rnd_vld_q, rnd_sgn_q, sat_q;

  // Round half away from zero on the magnitude, then restore the sign and clamp.
  always_comb begin
    if (fin_sgn_q) ext = EXT_W'($signed(fin_res_q));
    else           ext = EXT_W'(fin_res_q);
    neg   = ext[EXT_W-1];
    mag   = neg ? -ext : ext;
    half  = EXT_W'(1) << FRAC_BITS;
    half  = half >> 1;
    rnd   = (mag + half) >> FRAC_BITS;
    val   = neg ? -rnd : rnd;
    sat_v = val;
    sat_d = 1'b0;
    if (fin_sgn_q) begin
      if (val > S_MAX) begin
        sat_v = S_MAX;
        sat_d = 1'b1;
      end else if (val < S_MIN) begin
        sat_v = S_MIN;
        sat_d = 1'b1;
      end
    end else if (val > U_MAX) begin
      sat_v = U_MAX;
      sat_d = 1'b1;
    end
    res_d = sat_v[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_vld_q <= 1'b0;
      rnd_sgn_q <= 1'b0;
      res_q     <= '0;
      sat_q     <= 1'b0;
    end else if (adv) begin
      rnd_vld_q <= fin_vld_q;
      rnd_sgn_q <= fin_sgn_q;
      res_q     <= res_d;
      sat_q     <= sat_d;
    end
  end

  assign out_valid  = rnd_vld_q;
  assign out_signed = rnd_sgn_q;
  assign result     = res_q;
  assign sat_flag   = sat_q;
`else
  assign out_valid  = fin_vld_q;
  assign out_signed = fin_sgn_q;
  assign result     = fin_res_q;
`endif

endmodule

// File: tb/tb_mult_pipe_nxn.sv
// Self-checking bench for mult_pipe_nxn: directed vectors, stall, reset and random traffic
// against a plain-arithmetic product model with latency tracking (MULT_ROUND_EN aware).
module tb_mult_pipe_nxn;

  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int LAT   = 8;
  localparam int FRAC  = 4;
  localparam int OUTW  = 8;
`ifdef MULT_ROUND_EN
  localparam int RES_W   = OUTW;
  localparam int LAT_EFF = LAT + 1;
`else
  localparam int RES_W   = A_W + B_W;
  localparam int LAT_EFF = LAT;
`endif

  typedef struct {
    logic [63:0] res;
    logic        sgn;
    logic        sat;
    int          acc;
    int          stalls;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, in_valid, out_ready, a_signed, b_signed;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             in_ready, out_valid, out_signed;
  logic [RES_W-1:0] result;
`ifdef MULT_ROUND_EN
  logic             sat_flag;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_popped = 0;
  exp_t q[$];

  mult_pipe_nxn #(.A_W(A_W), .B_W(B_W), .LAT(LAT), .FRAC_BITS(FRAC), .OUT_W(OUTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef MULT_ROUND_EN
    .sat_flag  (sat_flag),
`endif
    .out_signed(out_signed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required finish", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] res, input logic sgn, input logic sat);
    exp_t e;
    e.res = res; e.sgn = sgn; e.sat = sat; e.acc = 0; e.stalls = 0;
    return e;
  endfunction

  // Reference: integer product of the two operands as interpreted by their mode bits.
  function automatic exp_t model(input logic [A_W-1:0] ma, input logic [B_W-1:0] mb,
                                 input logic sa, input logic sb);
    longint va, vb, p;
    logic [63:0] pv;
    logic        sgn;
    va  = sa ? longint'($signed(ma)) : longint'(ma);
    vb  = sb ? longint'($signed(mb)) : longint'(mb);
    p   = va * vb;
    sgn = sa | sb;
`ifdef MULT_ROUND_EN
    begin
      longint m, r, v, lo, hi;
      logic   sat;
      m   = (p < 0) ? -p : p;
      r   = (m + (longint'(1) << FRAC) / 2) / (longint'(1) << FRAC);
      v   = (p < 0) ? -r : r;
      lo  = sgn ? -(longint'(1) << (OUTW - 1)) : 0;
      hi  = sgn ? (longint'(1) << (OUTW - 1)) - 1 : (longint'(1) << OUTW) - 1;
      sat = 1'b0;
      if (v > hi) begin v = hi; sat = 1'b1; end
      if (v < lo) begin v = lo; sat = 1'b1; end
      pv  = v;
      return mk(64'(pv[RES_W-1:0]), sgn, sat);
    end
`else
    pv = p;
    return mk(64'(pv[RES_W-1:0]), sgn, 1'b0);
`endif
  endfunction

  // One clock of stimulus; outputs are sampled 1 time unit after the negedge.
  task automatic drive(input logic iv, input logic [A_W-1:0] ia, input logic [B_W-1:0] ib,
                       input logic ias, input logic ibs, input logic ordy,
                       input exp_t e, output logic took);
    exp_t h;
    in_valid = iv; a = ia; b = ib; a_signed = ias; b_signed = ibs; out_ready = ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(!out_valid || ordy));
    if (out_valid && !ordy) foreach (q[i]) q[i].stalls++;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'(0));
      end else if (ordy) begin
        h = q.pop_front();
        n_popped++;
        check("result", 64'(result), h.res);
        check("out_signed", 64'(out_signed), 64'(h.sgn));
`ifdef MULT_ROUND_EN
        check("sat_flag", 64'(sat_flag), 64'(h.sat));
`endif
        check("latency_edge", 64'(cyc), 64'(h.acc + LAT_EFF + h.stalls));
      end
    end
    took = iv && in_ready;
    if (took) begin
      e.acc    = cyc + 1;
      e.stalls = 0;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [A_W-1:0] ia, input logic [B_W-1:0] ib,
                      input logic ias, input logic ibs, input exp_t e);
    logic took;
    took = 1'b0;
    for (int i = 0; i < 50 && !took; i++) drive(1'b1, ia, ib, ias, ibs, 1'b1, e, took);
    if (!took) check("send_accept_timeout", 64'(took), 64'(1));
  endtask

  task automatic drain(input int limit);
    logic took;
    for (int i = 0; i < limit && q.size() != 0; i++)
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0), took);
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic idle(input int n);
    logic took;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0), took);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1 << (w - 1);
      2:       v = (32'd1 << w) - 1;
      3:       v = 32'd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic        took, pend, pas, pbs;
    logic [31:0] ra, rb;
    logic [A_W-1:0] pa;
    logic [B_W-1:0] pb;
    int          sent, base;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_out_signed", 64'(out_signed), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
`ifdef MULT_ROUND_EN
    check("reset_sat_flag", 64'(sat_flag), 64'(0));
`endif

`ifdef MULT_ROUND_EN
    send(8'd100, 8'd3, 1'b1, 1'b1, mk(64'd19, 1'b1, 1'b0));
    drain(40);
    send(8'd127, 8'd127, 1'b1, 1'b1, mk(64'd127, 1'b1, 1'b1));
    drain(40);
`else
    send(8'd200, 8'hFD, 1'b0, 1'b1, mk(64'hFDA8, 1'b1, 1'b0));
    drain(40);
    send(8'h80, 8'h80, 1'b1, 1'b1, mk(64'h4000, 1'b1, 1'b0));
    send(8'hFF, 8'hFF, 1'b0, 1'b0, mk(64'hFE01, 1'b0, 1'b0));
    send(8'h00, 8'hFB, 1'b1, 1'b1, mk(64'h0000, 1'b1, 1'b0));
    send(8'h07, 8'h00, 1'b1, 1'b0, mk(64'h0000, 1'b1, 1'b0));
    drain(40);
`endif

    // Back-to-back stream of 10 with a 3-cycle output stall once results are flowing.
    base = n_popped;
    sent = 0;
    pend = 1'b0;
    for (int k = 0; k < 60 && sent < 10; k++) begin
      if (!pend) begin
        ra = $urandom; rb = $urandom;
        pa = ra[A_W-1:0]; pb = rb[B_W-1:0]; pas = ra[31]; pbs = rb[31];
        pend = 1'b1;
      end
      drive(1'b1, pa, pb, pas, pbs, !(k >= LAT_EFF + 1 && k < LAT_EFF + 4),
            model(pa, pb, pas, pbs), took);
      if (took) begin pend = 1'b0; sent++; end
    end
    check("stream_sent", 64'(sent), 64'(10));
    drain(60);
    check("stream_results", 64'(n_popped - base), 64'(10));

    // Reset with five transactions in flight: nothing stale may come out afterwards.
    for (int i = 0; i < 5; i++) begin
      ra = $urandom; rb = $urandom;
      send(ra[A_W-1:0], rb[B_W-1:0], 1'b1, 1'b0, model(ra[A_W-1:0], rb[B_W-1:0], 1'b1, 1'b0));
    end
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    #1;
    check("rst_flush_out_valid", 64'(out_valid), 64'(0));
    check("rst_flush_result", 64'(result), 64'(0));
    idle(LAT_EFF + 6);
    send(8'hF6, 8'h05, 1'b1, 1'b1, model(8'hF6, 8'h05, 1'b1, 1'b1));
    drain(40);

    // Random traffic with random valid gaps and backpressure; operands held until accepted.
    sent = 0;
    pend = 1'b0;
    for (int k = 0; k < 4000 && sent < 400; k++) begin
      if (!pend && $urandom_range(0, 9) < 8) begin
        ra = pick(A_W); rb = pick(B_W);
        pa = ra[A_W-1:0]; pb = rb[B_W-1:0];
        pas = $urandom_range(0, 1) == 1; pbs = $urandom_range(0, 1) == 1;
        pend = 1'b1;
      end
      drive(pend, pa, pb, pas, pbs, $urandom_range(0, 3) != 0, model(pa, pb, pas, pbs), took);
      if (took) begin pend = 1'b0; sent++; end
    end
    check("random_sent", 64'(sent), 64'(400));
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
